// File: rtl/sfp_tile_acc.sv
// sfp_tile_acc: per-column tile accumulator and activation stage between
// the last PE row and the OFIFO. Each column sums acc_len beats in 1, 2 or 4
// independent SIMD lanes, optionally saturates, then applies ReLU to the
// result and holds it for one OFIFO write. A full OFIFO stalls the column.
module sfp_tile_acc #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int len_w   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in_psum,
    input  logic [col-1:0]           valid_in,
    output logic [col-1:0]           in_ready,
    input  logic [len_w-1:0]         acc_len,
    input  logic [1:0]               act_mode,
    input  logic                     relu_en,
    input  logic                     sat_en,
    input  logic                     ofifo_full,
    output logic [psum_bw*col-1:0]   out_accum,
    output logic [col-1:0]           wr_ofifo,
    output logic                     o_valid,
    output logic                     busy
);

    typedef enum logic {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    logic [len_w:0] eff_len;
    logic [col-1:0] col_busy;

    // Tile length with 0 promoted to 1; one bit wider so cnt+1 never overflows.
    always_comb begin
        eff_len = (acc_len == '0) ? {{len_w{1'b0}}, 1'b1} : {1'b0, acc_len};
    end

    genvar gi, gm, gl;
    generate
        for (gi = 0; gi < col; gi++) begin : g_col
            logic [psum_bw-1:0] acc_q, acc_d;
            logic [psum_bw-1:0] res_q, res_d;
            logic [len_w-1:0]   cnt_q, cnt_d;
            state_t             state_q, state_d;
            logic [psum_bw-1:0] in_word;
            logic [psum_bw-1:0] sum_sel;
            logic [psum_bw-1:0] relu_sel;
            logic               accept;
            logic               last_beat;

            assign in_word = in_psum[gi*psum_bw +: psum_bw];

            // All three lane splits are built in parallel; act_mode picks one.
            for (gm = 0; gm < 3; gm++) begin : g_mode
                localparam int LANES = 1 << gm;
                localparam int W     = psum_bw / LANES;
                logic [psum_bw-1:0] sum_v;
                logic [psum_bw-1:0] relu_v;

                for (gl = 0; gl < LANES; gl++) begin : g_lane
                    logic [W:0]   lane_sum;
                    logic [W-1:0] lane_res;

                    // Signed lane add in W+1 bits, then clamp or wrap to W bits.
                    always_comb begin
                        lane_sum = {acc_q[gl*W+W-1], acc_q[gl*W +: W]}
                                 + {in_word[gl*W+W-1], in_word[gl*W +: W]};
                        if (sat_en && (lane_sum[W] != lane_sum[W-1])) begin
                            lane_res = lane_sum[W] ? {1'b1, {(W-1){1'b0}}}
                                                   : {1'b0, {(W-1){1'b1}}};
                        end else begin
                            lane_res = lane_sum[W-1:0];
                        end
                    end

                    assign sum_v[gl*W +: W]  = lane_res;
                    assign relu_v[gl*W +: W] = (relu_en && lane_res[W-1]) ? '0 : lane_res;
                end
            end

            // Lane-split select; mode 3 behaves like mode 0.
            always_comb begin
                case (act_mode)
                    2'd1: begin
                        sum_sel  = g_mode[1].sum_v;
                        relu_sel = g_mode[1].relu_v;
                    end
                    2'd2: begin
                        sum_sel  = g_mode[2].sum_v;
                        relu_sel = g_mode[2].relu_v;
                    end
                    default: begin
                        sum_sel  = g_mode[0].sum_v;
                        relu_sel = g_mode[0].relu_v;
                    end
                endcase
            end

            assign accept    = valid_in[gi] && (state_q == ST_ACC);
            assign last_beat = ({1'b0, cnt_q} + 1'b1) >= eff_len;

            // Next-state: accumulate beats, latch result on the last one, drain when OFIFO has room.
            always_comb begin
                state_d = state_q;
                acc_d   = acc_q;
                cnt_d   = cnt_q;
                res_d   = res_q;
                if (state_q == ST_ACC) begin
                    if (accept) begin
                        if (last_beat) begin
                            res_d   = relu_sel;
                            acc_d   = '0;
                            cnt_d   = '0;
                            state_d = ST_DRAIN;
                        end else begin
                            acc_d = sum_sel;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else if (!ofifo_full) begin
                    state_d = ST_ACC;
                end
            end

            // Column state registers; reset discards any partial or undrained tile.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_ACC;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    res_q   <= '0;
                end else begin
                    state_q <= state_d;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    res_q   <= res_d;
                end
            end

            assign in_ready[gi]                         = (state_q == ST_ACC);
            assign wr_ofifo[gi]                         = (state_q == ST_DRAIN) && !ofifo_full;
            assign out_accum[gi*psum_bw +: psum_bw]     = res_q;
            assign col_busy[gi]                         = (cnt_q != '0) || (state_q == ST_DRAIN);
        end
    endgenerate

    assign o_valid = |wr_ofifo;
    assign busy    = |col_busy;

endmodule

// File: tb/tb_sfp_tile_acc.sv
// Directed bench for sfp_tile_acc with a per-column scoreboard of expected
// OFIFO words, popped whenever a column asserts its write strobe.
module tb_sfp_tile_acc;
    localparam int COL = 8;
    localparam int PB  = 16;
    localparam int LW  = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [PB*COL-1:0]   in_psum;
    logic [COL-1:0]      valid_in;
    logic [COL-1:0]      in_ready;
    logic [LW-1:0]       acc_len;
    logic [1:0]          act_mode;
    logic                relu_en;
    logic                sat_en;
    logic                ofifo_full;
    logic [PB*COL-1:0]   out_accum;
    logic [COL-1:0]      wr_ofifo;
    logic                o_valid;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [PB-1:0] sb [COL][$];
    int wr_cnt [COL] = '{default: 0};

    always #5 clk = ~clk;

    sfp_tile_acc #(.col(COL), .psum_bw(PB), .len_w(LW)) dut (
        .clk(clk), .reset(reset), .in_psum(in_psum), .valid_in(valid_in),
        .in_ready(in_ready), .acc_len(acc_len), .act_mode(act_mode),
        .relu_en(relu_en), .sat_en(sat_en), .ofifo_full(ofifo_full),
        .out_accum(out_accum), .wr_ofifo(wr_ofifo), .o_valid(o_valid), .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one beat on column k and hold it until accepted (bounded).
    task automatic beat(input int k, input logic [PB-1:0] v);
        int   tries = 0;
        logic took;
        valid_in[k]          = 1'b1;
        in_psum[k*PB +: PB]  = v;
        do begin
            took = in_ready[k];
            @(posedge clk);
            #1;
            tries++;
        end while (!took && tries < 50);
        valid_in[k] = 1'b0;
        chk($sformatf("beat_accept_col%0d", k), took, 1);
    endtask

    task automatic wait_idle();
        int tries = 0;
        while (busy !== 1'b0 && tries < 100) begin
            @(posedge clk);
            #1;
            tries++;
        end
        chk("wait_idle", busy, 0);
    endtask

    // Scoreboard: every OFIFO write must match the oldest expected word of its column.
    always @(negedge clk) begin
        for (int k = 0; k < COL; k++) begin
            if (wr_ofifo[k] === 1'b1) begin
                logic [PB-1:0] e;
                wr_cnt[k]++;
                chk($sformatf("sb_has_entry_col%0d", k), sb[k].size() > 0, 1);
                if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    $display("ofifo write col=%0d data=%04h expected=%04h", k, out_accum[k*PB +: PB], e);
                    chk($sformatf("ofifo_data_col%0d", k), out_accum[k*PB +: PB], e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    t5_wr   [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        logic          t5_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic          t5_v0   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          t5_v1   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [PB-1:0] t5_d0   [6] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0};
        logic [PB-1:0] t5_d1   [6] = '{16'd10, 16'd0, 16'd20, 16'd0, 16'd30, 16'd0};

        reset = 1'b0; in_psum = '0; valid_in = '0; acc_len = 8'd1; act_mode = 2'd0;
        relu_en = 1'b0; sat_en = 1'b0; ofifo_full = 1'b0;
        #2;
        chk("reset_out_accum", out_accum, 0);
        chk("reset_in_ready", in_ready, 8'hFF);
        chk("reset_busy", busy, 0);
        chk("reset_wr_ofifo", wr_ofifo, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Mode 0, 4-beat tile on column 0
        acc_len = 8'd4; act_mode = 2'd0;
        sb[0].push_back(16'd100);
        beat(0, 16'd100); beat(0, -16'sd30); beat(0, 16'd5); beat(0, 16'd25);
        @(negedge clk);
        chk("t1_wr_pulse", wr_ofifo[0], 1);
        chk("t1_in_ready_drain", in_ready[0], 0);
        chk("t1_out_accum", out_accum[15:0], 16'd100);
        chk("t1_o_valid", o_valid, 1);
        @(posedge clk); #1;
        chk("t1_wr_low", wr_ofifo[0], 0);
        chk("t1_in_ready_back", in_ready[0], 1);
        chk("t1_wr_count", wr_cnt[0], 1);

        // Mode 1, two lanes, ReLU on column 3; then prove acc was cleared
        acc_len = 8'd2; act_mode = 2'd1; relu_en = 1'b1;
        sb[3].push_back(16'h0008);
        beat(3, 16'hFB07); beat(3, 16'h0201);
        wait_idle();
        chk("t2_word", out_accum[3*PB +: PB], 16'h0008);
        relu_en = 1'b0; acc_len = 8'd1;
        sb[3].push_back(16'h0101);
        beat(3, 16'h0101);
        wait_idle();

        // Mode 2, four 4-bit lanes on column 1, saturating then wrapping
        acc_len = 8'd2; act_mode = 2'd2; sat_en = 1'b1;
        sb[1].push_back(16'h8007);
        beat(1, 16'h8006); beat(1, 16'hF005);
        wait_idle();
        sat_en = 1'b0;
        sb[1].push_back(16'h700B);
        beat(1, 16'h8006); beat(1, 16'hF005);
        wait_idle();

        // Backpressure on column 2
        act_mode = 2'd0; acc_len = 8'd2; ofifo_full = 1'b1;
        sb[2].push_back(16'd30);
        beat(2, 16'd10); beat(2, 16'd20);
        valid_in[2] = 1'b1; in_psum[2*PB +: PB] = 16'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_ready_c%0d", c), in_ready[2], 0);
            chk($sformatf("t4_stall_wr_c%0d", c), wr_ofifo[2], 0);
            chk($sformatf("t4_stall_res_c%0d", c), out_accum[2*PB +: PB], 16'd30);
            @(posedge clk); #1;
        end
        ofifo_full = 1'b0; valid_in[2] = 1'b0;
        @(negedge clk);
        chk("t4_release_wr", wr_ofifo[2], 1);
        @(posedge clk); #1;
        chk("t4_wr_low", wr_ofifo[2], 0);
        chk("t4_ready_back", in_ready[2], 1);
        chk("t4_no_stall_beats", busy, 0);
        chk("t4_one_pulse", wr_cnt[2], 1);
        sb[2].push_back(16'd3);
        beat(2, 16'd1); beat(2, 16'd2);
        wait_idle();

        // Mixed columns, acc_len 3: col 0 every cycle, col 1 every other cycle
        acc_len = 8'd3;
        sb[0].push_back(16'd6);
        sb[1].push_back(16'd60);
        for (int s = 0; s < 6; s++) begin
            valid_in[0] = t5_v0[s]; in_psum[15:0]  = t5_d0[s];
            valid_in[1] = t5_v1[s]; in_psum[31:16] = t5_d1[s];
            @(posedge clk); #1;
            valid_in[1:0] = 2'b00;
            @(negedge clk);
            chk($sformatf("t5_wr_s%0d", s), wr_ofifo[1:0], t5_wr[s]);
            chk($sformatf("t5_o_valid_s%0d", s), o_valid, |t5_wr[s]);
            chk($sformatf("t5_busy_s%0d", s), busy, t5_busy[s]);
        end

        // acc_len 0 behaves as a single-beat tile
        acc_len = 8'd0;
        sb[4].push_back(16'd55);
        beat(4, 16'd55);
        wait_idle();

        // Asynchronous reset mid-tile, then a clean tile
        acc_len = 8'd4;
        beat(0, 16'd1); beat(0, 16'd1);
        chk("t6_busy_mid", busy, 1);
        #2; reset = 1'b0;
        #1;
        chk("t6_rst_out_accum", out_accum, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", in_ready, 8'hFF);
        chk("t6_rst_wr", wr_ofifo, 0);
        chk("t6_rst_o_valid", o_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        sb[0].push_back(16'd4);
        beat(0, 16'd1); beat(0, 16'd1); beat(0, 16'd1); beat(0, 16'd1);
        wait_idle();
        @(posedge clk); #1;

        for (int k = 0; k < COL; k++)
            chk($sformatf("sb_drained_col%0d", k), sb[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sfp_tile_acc.md
# sfp_tile_acc

Per-column output accumulator and activation stage for the MAC array, sitting between the last PE row and the output FIFO. Each column sums a programmable number of partial-sum beats (one output tile), then applies optional saturation and ReLU and writes one result word to the OFIFO. It supports 1, 2 or 4 packed SIMD lanes per column word. A stalled OFIFO backpressures the array through a per-column ready.

## Interface
- col, 8, number of columns
- psum_bw, 16, psum word width per column; must be a multiple of 4
- len_w, 8, width of the accumulation-length field

- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_psum  input  psum_bw*col  column k occupies bits [(k+1)*psum_bw-1 : k*psum_bw]
- valid_in  input  col  per-column beat valid
- in_ready  output  col  per-column beat accept
- acc_len  input  len_w  beats per tile; 0 is treated as 1
- act_mode  input  2  0: 1 lane of psum_bw; 1: 2 lanes of psum_bw/2; 2: 4 lanes of psum_bw/4; 3: same as 0
- relu_en  input  1  clamp negative lanes to 0 on output
- sat_en  input  1  saturate (1) or wrap (0) on lane overflow
- ofifo_full  input  1  OFIFO full, shared by all columns
- out_accum  output  psum_bw*col  per-column result register
- wr_ofifo  output  col  per-column OFIFO write strobe
- o_valid  output  1  OR of wr_ofifo
- busy  output  1  any column has a partial tile or a pending result

## Operation
- Each column has its own FSM with two states, ACC and DRAIN, plus these registers:
  - accumulator acc (psum_bw bits)
  - beat counter cnt (len_w bits)
  - result register res
- Beat accept: a beat is accepted when valid_in[k] && in_ready[k], with in_ready[k] = (state == ACC).
  - valid_in[k] while in DRAIN is ignored; the beat is dropped.
- Lane arithmetic, with w = psum_bw / lanes:
  - Each lane computes sum = acc_lane + in_lane, signed, in w+1 bits. Lanes are independent and there is no carry between lanes.
  - sat_en = 1: clamp the sum to [-2^(w-1), 2^(w-1)-1].
  - sat_en = 0: keep the low w bits (wrap).
- Accepted beat that is not the last (cnt + 1 < max(acc_len, 1)): acc <= lane sums, cnt <= cnt + 1.
- Accepted last beat:
  - res <= lane sums, with ReLU applied per lane if relu_en (negative lane becomes 0).
  - acc <= 0, cnt <= 0, state <= DRAIN.
- ReLU is applied to res only, never to acc; partial sums stay signed.
- In DRAIN: wr_ofifo[k] = !ofifo_full, combinational. In a cycle where wr_ofifo[k] = 1, state <= ACC.
- out_accum[k] = res. res holds until the next tile completes.
- o_valid = |wr_ofifo.
- busy = any column with cnt != 0 or in DRAIN.
- act_mode, acc_len, relu_en and sat_en must only change while busy = 0. The block samples them live and does no latching.
- Columns advance independently. Several columns may drain in the same cycle, each asserting its own wr_ofifo bit.
- Reset (reset = 0), applied asynchronously at any time including mid-tile:
  - acc, cnt and res are cleared to 0 and every state goes to ACC.
  - Partial tiles and undrained results are discarded.
  - Output values under reset: out_accum = 0, wr_ofifo = 0, o_valid = 0, busy = 0, in_ready = all 1s.

## Timing
- Beats are accepted at one per cycle per column with no bubbles while in ACC.
- Last beat accepted at edge t:
  - res is visible on out_accum and the column is in DRAIN from t+1.
  - If ofifo_full = 0 at t+1: wr_ofifo[k] = 1 during t+1, and in_ready[k] returns to 1 at t+2.
- Minimum tile period is acc_len + 1 cycles. There is one DRAIN bubble per tile.
- With ofifo_full held high, the column stays in DRAIN with in_ready[k] = 0 and res stable. wr_ofifo[k] rises in the first cycle ofifo_full is low.
- acc_len = 1: every accepted beat completes a tile.
- Counter boundary: acc_len = 2^len_w - 1 is the largest supported tile. cnt never wraps.

## Test plan
- Mode 0, acc_len = 4, column 0, beats 100, -30, 5, 25, relu_en = 0, ofifo_full = 0 -> out_accum[15:0] = 100, wr_ofifo[0] = 1 for exactly 1 cycle on the cycle after the 4th beat, then in_ready[0] = 1.
- Mode 1, acc_len = 2, column 3, packed beats {hi = -5, lo = 7} then {hi = 2, lo = 1}, relu_en = 1 -> word = {0x00, 0x08}; acc is cleared afterwards.
- Saturation, mode 2 (w = 4), sat_en = 1, lane 0 receives 6 then 5 with acc_len = 2 -> lane 0 = 7. The same stimulus with sat_en = 0 -> lane 0 = 0xB (-5).
- Backpressure: ofifo_full = 1 across tile completion, held 5 cycles, valid_in kept high -> in_ready[k] = 0, no wr_ofifo, out_accum stable. Release ofifo_full -> exactly one wr_ofifo pulse. Beats offered during the stall are not counted.
- Mixed columns: col 0 with acc_len = 3 fed every cycle, col 1 fed every other cycle -> each wr_ofifo bit fires after its own 3rd accepted beat; o_valid is the OR of the two strobes; busy drops only after both have drained.
- Reset mid-tile after 2 of 4 beats -> outputs go to reset values immediately. The next 4-beat tile of all 1s yields 4, with no residue from the aborted tile.
